// File: rtl/hack_fetch.sv
// Instruction-fetch stage: requests ROM words at the current PC, holds the
// returned word for execute under valid/ready, steers the PC inc/load strobes
// and drops ROM responses made stale by a taken jump.
module hack_fetch #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     pc,
    output logic [WIDTH-1:0]     pc_in,
    output logic                 pc_load,
    output logic                 pc_inc,
    output logic                 rom_req,
    output logic [ADDR_BITS-1:0] rom_addr,
    input  logic                 rom_ack,
    input  logic [WIDTH-1:0]     rom_data,
    output logic [WIDTH-1:0]     instr,
    output logic [WIDTH-1:0]     instr_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    input  logic                 jump_valid,
    input  logic [WIDTH-1:0]     jump_addr,
    output logic [WIDTH-1:0]     fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DISCARD
    } state_e;

    state_e                 state_q,       state_d;
    logic                   rom_req_q,     rom_req_d;
    logic [ADDR_BITS-1:0]   rom_addr_q,    rom_addr_d;
    logic [WIDTH-1:0]       req_pc_q,      req_pc_d;
    logic [WIDTH-1:0]       instr_q,       instr_d;
    logic [WIDTH-1:0]       instr_pc_q,    instr_pc_d;
    logic                   instr_valid_q, instr_valid_d;
    logic [WIDTH-1:0]       count_q,       count_d;

    // PC control strobes: a jump always wins over an increment, both gated by reset
    always_comb begin
        pc_in   = jump_addr;
        pc_load = reset & jump_valid;
        pc_inc  = reset & (state_q == S_REQ) & rom_ack & ~jump_valid;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        rom_req_d     = rom_req_q;
        rom_addr_d    = rom_addr_q;
        req_pc_d      = req_pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        count_d       = count_q;

        if (instr_valid_q && instr_ready) begin
            count_d = count_q + WIDTH'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                // Hold off one cycle on a jump so the PC settles to the target
                if (!jump_valid) begin
                    state_d    = S_REQ;
                    rom_req_d  = 1'b1;
                    rom_addr_d = pc[ADDR_BITS-1:0];
                    req_pc_d   = pc;
                end
            end
            S_REQ: begin
                if (rom_ack && !jump_valid) begin
                    state_d       = S_HOLD;
                    rom_req_d     = 1'b0;
                    instr_d       = rom_data;
                    instr_pc_d    = req_pc_q;
                    instr_valid_d = 1'b1;
                end else if (rom_ack) begin
                    state_d   = S_IDLE;
                    rom_req_d = 1'b0;
                end else if (jump_valid) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                // The in-flight read must still complete before a new one is issued
                if (rom_ack) begin
                    state_d   = S_IDLE;
                    rom_req_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (jump_valid) begin
                    state_d       = S_IDLE;
                    instr_valid_d = 1'b0;
                end else if (instr_ready) begin
                    state_d       = S_REQ;
                    instr_valid_d = 1'b0;
                    rom_req_d     = 1'b1;
                    rom_addr_d    = pc[ADDR_BITS-1:0];
                    req_pc_d      = pc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            rom_req_q     <= 1'b0;
            rom_addr_q    <= '0;
            req_pc_q      <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            rom_req_q     <= rom_req_d;
            rom_addr_q    <= rom_addr_d;
            req_pc_q      <= req_pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            count_q       <= count_d;
        end
    end

    assign rom_req     = rom_req_q;
    assign rom_addr    = rom_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_hack_fetch.sv
// Bench for hack_fetch: acts as PC register and ROM, and checks the DUT every
// cycle against a transaction-level model (outstanding / stale / held flags).
module tb_hack_fetch;

    localparam int W  = 16;
    localparam int AB = 15;

    logic          clock = 1'b0;
    logic          reset;
    logic [W-1:0]  pc;
    logic [W-1:0]  pc_in;
    logic          pc_load;
    logic          pc_inc;
    logic          rom_req;
    logic [AB-1:0] rom_addr;
    logic          rom_ack;
    logic [W-1:0]  rom_data;
    logic [W-1:0]  instr;
    logic [W-1:0]  instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic          jump_valid;
    logic [W-1:0]  jump_addr;
    logic [W-1:0]  fetch_count;

    always #5 clock = ~clock;

    hack_fetch #(.WIDTH(W), .ADDR_BITS(AB)) dut (
        .clock       (clock),
        .reset       (reset),
        .pc          (pc),
        .pc_in       (pc_in),
        .pc_load     (pc_load),
        .pc_inc      (pc_inc),
        .rom_req     (rom_req),
        .rom_addr    (rom_addr),
        .rom_ack     (rom_ack),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump_valid  (jump_valid),
        .jump_addr   (jump_addr),
        .fetch_count (fetch_count)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Model: a read is outstanding (busy), possibly invalidated by a jump
    // (stale); a word may be waiting for execute (have).
    bit          m_busy, m_stale, m_have;
    logic [W-1:0]  m_pc, m_req_pc, m_instr, m_ipc, m_count;
    logic [AB-1:0] m_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_regs();
        chk("rom_req",     32'(rom_req),     32'(m_busy));
        chk("rom_addr",    32'(rom_addr),    32'(m_addr));
        chk("instr_valid", 32'(instr_valid), 32'(m_have));
        chk("instr",       32'(instr),       32'(m_instr));
        chk("instr_pc",    32'(instr_pc),    32'(m_ipc));
        chk("fetch_count", 32'(fetch_count), 32'(m_count));
    endtask

    task automatic compare_comb();
        chk("pc_load", 32'(pc_load), 32'(reset & jump_valid));
        chk("pc_inc",  32'(pc_inc),
            32'(reset & m_busy & ~m_stale & rom_ack & ~jump_valid));
        chk("pc_in",   32'(pc_in),   32'(jump_addr));
    endtask

    function automatic void issue(input logic [W-1:0] p);
        m_busy   = 1'b1;
        m_stale  = 1'b0;
        m_addr   = p[AB-1:0];
        m_req_pc = p;
    endfunction

    function automatic void model_update();
        bit ld;
        bit inc;
        ld  = reset & jump_valid;
        inc = reset & m_busy & ~m_stale & rom_ack & ~jump_valid;
        if (!reset) begin
            m_busy  = 1'b0;
            m_stale = 1'b0;
            m_have  = 1'b0;
            m_addr  = '0;
            m_instr = '0;
            m_ipc   = '0;
            m_count = '0;
        end else begin
            if (m_have && instr_ready) m_count = m_count + 16'd1;
            if (m_have) begin
                if (jump_valid) m_have = 1'b0;
                else if (instr_ready) begin
                    m_have = 1'b0;
                    issue(m_pc);
                end
            end else if (m_busy) begin
                if (rom_ack) begin
                    if (!m_stale && !jump_valid) begin
                        m_have  = 1'b1;
                        m_instr = rom_data;
                        m_ipc   = m_req_pc;
                    end
                    m_busy  = 1'b0;
                    m_stale = 1'b0;
                end else if (jump_valid) begin
                    m_stale = 1'b1;
                end
            end else if (!jump_valid) begin
                issue(m_pc);
            end
        end
        if (ld)       m_pc = jump_addr;
        else if (inc) m_pc = m_pc + 16'd1;
    endfunction

    // One clock: check registered outputs, drive inputs, check strobes, advance model
    task automatic step(input bit rst, input bit rdy, input bit jv, input bit ack,
                        input logic [W-1:0] ja, input logic [W-1:0] data);
        @(negedge clock);
        compare_regs();
        reset       = rst;
        instr_ready = rdy;
        jump_valid  = jv;
        jump_addr   = ja;
        rom_ack     = ack;
        rom_data    = data;
        pc          = m_pc;
        #1 compare_comb();
        @(posedge clock);
        model_update();
    endtask

    int unsigned wait_cnt;

    initial begin
        reset       = 1'b0;
        instr_ready = 1'b0;
        jump_valid  = 1'b0;
        jump_addr   = '0;
        rom_ack     = 1'b0;
        rom_data    = '0;
        pc          = '0;
        m_busy = 1'b0; m_stale = 1'b0; m_have = 1'b0;
        m_pc = '0; m_req_pc = '0; m_instr = '0; m_ipc = '0; m_count = '0; m_addr = '0;
        @(posedge clock);

        // Reset for two cycles with pc=0
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1 chk("lit_rst_valid", 32'(instr_valid), 0);
        chk("lit_rst_count", 32'(fetch_count), 0);

        // Release: request at pc=0 one cycle later
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1 chk("lit_first_req", 32'(rom_req), 1);
        chk("lit_first_addr", 32'(rom_addr), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h1234);
        #1 chk("lit_instr", 32'(instr), 32'h1234);
        chk("lit_instr_pc", 32'(instr_pc), 0);
        chk("lit_valid", 32'(instr_valid), 1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1 chk("lit_next_addr", 32'(rom_addr), 1);
        chk("lit_count1", 32'(fetch_count), 1);
        chk("lit_valid_drop", 32'(instr_valid), 0);

        // Execute stalls for five cycles
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h5678);
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1 chk("lit_stall_instr", 32'(instr), 32'h5678);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1 chk("lit_after_stall_addr", 32'(rom_addr), 2);

        // Jump while read outstanding: later ack is discarded
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'hDEAD);
        #1 chk("lit_discard_valid", 32'(instr_valid), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1 chk("lit_jump_addr", 32'(rom_addr), 32'h0040);

        // Ack and jump together
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1 chk("lit_ackjump_addr", 32'(rom_addr), 32'h0010);

        // fetch_count wrap, starting from a preloaded 0xFFFE
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hAAAA);
        force dut.count_q = 16'hFFFE;
        #1 release dut.count_q;
        m_count = 16'hFFFE;
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h5555);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1 chk("lit_wrap", 32'(fetch_count), 0);

        // Reset mid-REQ, then a late ack
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hBEEF);
        #1 chk("lit_late_ack_valid", 32'(instr_valid), 0);
        chk("lit_late_ack_count", 32'(fetch_count), 0);

        // Randomized traffic with variable ROM latency and spurious acks
        wait_cnt = $urandom_range(0, 3);
        for (int i = 0; i < 4000; i++) begin
            bit ack;
            ack = 1'b0;
            if (m_busy) begin
                if (wait_cnt == 0) begin
                    ack = 1'b1;
                    wait_cnt = $urandom_range(0, 3);
                end else begin
                    wait_cnt--;
                end
            end else begin
                ack = ($urandom_range(0, 9) == 0);
            end
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 7) == 0), ack, 16'($urandom), 16'($urandom));
        end

        @(negedge clock);
        compare_regs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
